// File: rtl/lcd_rx_decoder.sv
// lcd_rx_decoder: RGB565 parallel-LCD receiver giving pixel coordinates, measured geometry, lock and error pulses.
// Define LCD_RX_CHECKSUM_EN to enable the per-frame pixel checksum on frame_sum; otherwise frame_sum is tied to 0.
module lcd_rx_decoder #(
  parameter int VS_POL = 1,
  parameter int MAX_W  = 1024,
  parameter int MAX_H  = 600
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        LCD_DE,
  input  logic        LCD_HSYNC,
  input  logic        LCD_VSYNC,
  input  logic [4:0]  LCD_R,
  input  logic [5:0]  LCD_G,
  input  logic [4:0]  LCD_B,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        frame_done,
  output logic [15:0] active_w,
  output logic [15:0] active_h,
  output logic        locked,
  output logic        err,
  output logic [15:0] frame_sum
);
  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  // One past the limit marks a saturated counter, so a saturated line or frame never passes the lock check.
  localparam logic [15:0] MAX_W16 = 16'(MAX_W);
  localparam logic [15:0] MAX_W1  = 16'(MAX_W + 1);
  localparam logic [15:0] MAX_H16 = 16'(MAX_H);
  localparam logic [15:0] MAX_H1  = 16'(MAX_H + 1);

  logic unused_hsync;
  assign unused_hsync = LCD_HSYNC;

  logic        vs_in;
  assign vs_in = (VS_POL != 0) ? LCD_VSYNC : ~LCD_VSYNC;

  logic        de_s_q, de_s_d, vs_s_q, vs_s_d, de_p_q, de_p_d, vs_p_q, vs_p_d;
  logic [15:0] rgb_s_q, rgb_s_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d, first_w_q, first_w_d;
  logic        have_line_q, have_line_d, uniform_q, uniform_d;
  logic        pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
  logic        locked_q, locked_d, err_q, err_d;
  logic [15:0] pix_data_q, pix_data_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] active_w_q, active_w_d, active_h_q, active_h_d;

  logic        fe, lc, px_ok, ovf_err, uni_eff, frame_ok;
  logic [15:0] y_inc, h_eff, fw_eff, bx, by;

  always_comb begin
    de_s_d  = LCD_DE;
    vs_s_d  = vs_in;
    rgb_s_d = {LCD_R, LCD_G, LCD_B};
    de_p_d  = de_s_q;
    vs_p_d  = vs_s_q;

    fe = vs_s_q & ~vs_p_q;
    lc = de_p_q & ~de_s_q;

    // A line closing on the frame-edge cycle still belongs to the frame being closed.
    y_inc   = (y_q >= MAX_H1) ? y_q : y_q + 16'd1;
    h_eff   = lc ? y_inc : y_q;
    fw_eff  = (lc && !have_line_q) ? x_q : first_w_q;
    uni_eff = uniform_q & ~(lc & have_line_q & (x_q != first_w_q));

    bx = (fe | lc) ? 16'd0 : x_q;
    by = fe ? 16'd0 : (lc ? y_inc : y_q);
    x_d = bx;
    y_d = by;
    px_ok   = 1'b0;
    ovf_err = 1'b0;

    first_w_d   = first_w_q;
    have_line_d = have_line_q;
    uniform_d   = uniform_q;
    if (lc) begin
      if (!have_line_q) begin
        first_w_d   = x_q;
        have_line_d = 1'b1;
      end else if (x_q != first_w_q) begin
        uniform_d = 1'b0;
      end
    end

    if (de_s_q) begin
      if (by >= MAX_H16) begin
        y_d     = MAX_H1;
        ovf_err = (by == MAX_H16);
      end else if (bx >= MAX_W16) begin
        x_d     = MAX_W1;
        ovf_err = (bx == MAX_W16);
      end else begin
        px_ok = 1'b1;
        x_d   = bx + 16'd1;
      end
    end

    state_d      = state_q;
    frame_done_d = 1'b0;
    err_d        = ovf_err;
    active_w_d   = active_w_q;
    active_h_d   = active_h_q;
    frame_ok     = (h_eff != 16'd0) && uni_eff && (fw_eff != 16'd0) &&
                   (fw_eff <= MAX_W16) && (h_eff <= MAX_H16);
    if (fe) begin
      first_w_d   = 16'd0;
      have_line_d = 1'b0;
      uniform_d   = 1'b1;
      if (state_q == SEARCH) begin
        state_d = MEASURE;
      end else begin
        frame_done_d = 1'b1;
        active_w_d   = fw_eff;
        active_h_d   = h_eff;
        if (state_q == MEASURE) begin
          if (frame_ok) state_d = LOCKED;
          else          err_d   = 1'b1;
        end else if (fw_eff != active_w_q || h_eff != active_h_q || !uni_eff) begin
          err_d   = 1'b1;
          state_d = MEASURE;
        end
      end
    end
    if (ovf_err && state_d == LOCKED) state_d = MEASURE;

    locked_d    = (state_d == LOCKED);
    pix_valid_d = px_ok;
    pix_data_d  = px_ok ? rgb_s_q : pix_data_q;
    pix_x_d     = px_ok ? bx : pix_x_q;
    pix_y_d     = px_ok ? by : pix_y_q;
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      de_s_q <= 1'b0;  vs_s_q <= 1'b0;  de_p_q <= 1'b0;  vs_p_q <= 1'b0;
      rgb_s_q <= '0;   state_q <= SEARCH;
      x_q <= '0;       y_q <= '0;       first_w_q <= '0;
      have_line_q <= 1'b0;  uniform_q <= 1'b0;
      pix_valid_q <= 1'b0;  frame_done_q <= 1'b0;  locked_q <= 1'b0;  err_q <= 1'b0;
      pix_data_q <= '0;  pix_x_q <= '0;  pix_y_q <= '0;
      active_w_q <= '0;  active_h_q <= '0;
    end else begin
      de_s_q <= de_s_d;  vs_s_q <= vs_s_d;  de_p_q <= de_p_d;  vs_p_q <= vs_p_d;
      rgb_s_q <= rgb_s_d;  state_q <= state_d;
      x_q <= x_d;        y_q <= y_d;        first_w_q <= first_w_d;
      have_line_q <= have_line_d;  uniform_q <= uniform_d;
      pix_valid_q <= pix_valid_d;  frame_done_q <= frame_done_d;
      locked_q <= locked_d;        err_q <= err_d;
      pix_data_q <= pix_data_d;  pix_x_q <= pix_x_d;  pix_y_q <= pix_y_d;
      active_w_q <= active_w_d;  active_h_q <= active_h_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign frame_done = frame_done_q;
  assign active_w   = active_w_q;
  assign active_h   = active_h_q;
  assign locked     = locked_q;
  assign err        = err_q;

`ifdef LCD_RX_CHECKSUM_EN
  logic [15:0] sum_q, sum_d, frame_sum_q, frame_sum_d, px_add;

  // A pixel sampled on the frame-edge cycle starts the new frame's sum.
  always_comb begin
    px_add      = px_ok ? rgb_s_q : 16'd0;
    sum_d       = fe ? px_add : sum_q + px_add;
    frame_sum_d = frame_done_d ? sum_q : frame_sum_q;
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      sum_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      sum_q       <= sum_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = 16'd0;
`endif
endmodule

// File: tb/tb_lcd_rx_decoder.sv
// Directed bench for lcd_rx_decoder (MAX_W=16): lock sequence, width error, merged line/frame close,
// line overflow, mid-frame reset and, when LCD_RX_CHECKSUM_EN is defined, the frame checksum.
module tb_lcd_rx_decoder;
  logic        PixelClk = 1'b0;
  logic        nRST;
  logic        de, hs, vs;
  logic [15:0] din;
  logic        pix_valid, frame_done, locked, err;
  logic [15:0] pix_data, pix_x, pix_y, active_w, active_h, frame_sum;

`ifdef LCD_RX_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  always #5 PixelClk = ~PixelClk;

  lcd_rx_decoder #(.VS_POL(1), .MAX_W(16), .MAX_H(600)) u_dut (
    .PixelClk(PixelClk), .nRST(nRST), .LCD_DE(de), .LCD_HSYNC(hs), .LCD_VSYNC(vs),
    .LCD_R(din[15:11]), .LCD_G(din[10:5]), .LCD_B(din[4:0]),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_done(frame_done), .active_w(active_w), .active_h(active_h),
    .locked(locked), .err(err), .frame_sum(frame_sum)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse and pixel bookkeeping, sampled on the falling edge.
  int          cyc = 0, fd_cnt = 0, err_cnt = 0, pv_cnt = 0, err_cyc = 0, last_pv_cyc = 0;
  logic [15:0] last_x = '0, last_y = '0, last_d = '0;

  always @(negedge PixelClk) begin
    cyc <= cyc + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (pix_valid) begin
      pv_cnt      <= pv_cnt + 1;
      last_pv_cyc <= cyc;
      last_x      <= pix_x;
      last_y      <= pix_y;
      last_d      <= pix_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge PixelClk);
    #1;
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      de = 1'b0; hs = 1'b1; vs = v;
      tick();
    end
  endtask

  task automatic pixels(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) begin
      de = 1'b1; hs = 1'b0; vs = 1'b0; din = d;
      tick();
    end
  endtask

  task automatic line(input int w, input logic [15:0] d);
    pixels(w, d);
    idle(3, 1'b0);
  endtask

  task automatic body(input int h, input int w, input logic [15:0] d);
    for (int i = 0; i < h; i++) line(w, d);
  endtask

  task automatic frame_edge();
    idle(2, 1'b1);
    idle(2, 1'b0);
  endtask

  int fd0, err0, pv0;

  initial begin
    nRST = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0; din = '0;
    repeat (3) tick();
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_pix_xy", 32'({pix_x, pix_y}), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_active_wh", 32'({active_w, active_h}), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    check("rst_frame_sum", 32'(frame_sum), 0);
    nRST = 1'b1;
    idle(3, 1'b0);

    // Three 8x4 frames: first edge only leaves SEARCH, second locks.
    frame_edge();
    check("search_edge_no_done", 32'(fd_cnt), 0);
    check("search_edge_unlocked", 32'(locked), 0);
    body(4, 8, 16'h0001);
    frame_edge();
    check("lock_2nd_edge", 32'(locked), 1);
    check("active_w_8", 32'(active_w), 8);
    check("active_h_4", 32'(active_h), 4);
    check("sum_frame2", 32'(frame_sum), CSUM ? 32'h20 : 32'h0);
    body(4, 8, 16'h0001);
    frame_edge();
    body(4, 8, 16'h0001);
    check("three_frames_done_x2", 32'(fd_cnt), 2);
    check("three_frames_no_err", 32'(err_cnt), 0);
    check("pixel_count_96", 32'(pv_cnt), 96);
    check("last_pixel_xy", 32'({last_x, last_y}), 32'h0007_0003);
    check("last_pixel_data", 32'(last_d), 32'h0001);

    // Locked, then a frame with one 7-pixel line.
    frame_edge();
    check("still_locked", 32'(locked), 1);
    line(8, 16'h0001); line(7, 16'h0001); line(8, 16'h0001); line(8, 16'h0001);
    frame_edge();
    check("short_line_err", 32'(err_cnt), 1);
    check("short_line_unlock", 32'(locked), 0);
    check("short_line_active_w", 32'(active_w), 8);
    body(4, 8, 16'h0001);
    frame_edge();
    check("relock_clean", 32'(locked), 1);
    check("relock_no_new_err", 32'(err_cnt), 1);

    // Last line's DE fall sampled together with the VSYNC rise.
    body(3, 8, 16'h0001);
    pixels(8, 16'h0001);
    frame_edge();
    check("merged_active_h", 32'(active_h), 4);
    check("merged_active_w", 32'(active_w), 8);
    check("merged_locked", 32'(locked), 1);
    check("merged_done_count", 32'(fd_cnt), 6);
    de = 1'b1; hs = 1'b0; vs = 1'b0; din = 16'h1234;
    tick();
    check("latency_not_yet", 32'(pix_valid), 0);
    din = 16'h0001;
    tick();
    check("latency_valid", 32'(pix_valid), 1);
    check("first_px_xy", 32'({pix_x, pix_y}), 0);
    check("first_px_data", 32'(pix_data), 32'h1234);
    pixels(6, 16'h0001);
    idle(3, 1'b0);
    body(3, 8, 16'h0001);

    // 20-pixel line against MAX_W=16.
    frame_edge();
    check("pre_ovf_locked", 32'(locked), 1);
    pv0 = pv_cnt; err0 = err_cnt;
    pixels(20, 16'h0001);
    idle(3, 1'b0);
    check("ovf_valid_count", 32'(pv_cnt - pv0), 16);
    check("ovf_err_once", 32'(err_cnt - err0), 1);
    check("ovf_err_after_x15", 32'(err_cyc - last_pv_cyc), 1);
    check("ovf_last_x", 32'(last_x), 15);
    check("ovf_to_measure", 32'(locked), 0);
    body(3, 8, 16'h0001);
    frame_edge();
    check("ovf_frame_err", 32'(err_cnt - err0), 2);
    check("ovf_frame_unlocked", 32'(locked), 0);
    body(4, 8, 16'h0001);
    frame_edge();
    check("ovf_relock", 32'(locked), 1);

    // Reset asserted at pixel (3,2) while locked.
    body(2, 8, 16'h0001);
    pixels(4, 16'h0001);
    #2 nRST = 1'b0;
    #1;
    check("midrst_locked", 32'(locked), 0);
    check("midrst_active_wh", 32'({active_w, active_h}), 0);
    check("midrst_pix_valid", 32'(pix_valid), 0);
    check("midrst_pix_xy", 32'({pix_x, pix_y}), 0);
    check("midrst_pix_data", 32'(pix_data), 0);
    check("midrst_frame_sum", 32'(frame_sum), 0);
    #1 nRST = 1'b1;
    fd0 = fd_cnt;
    pixels(4, 16'h0001);
    idle(3, 1'b0);
    line(8, 16'h0001);
    frame_edge();
    check("midrst_no_done", 32'(fd_cnt - fd0), 0);
    check("midrst_search_unlocked", 32'(locked), 0);
    body(4, 8, 16'h0001);
    frame_edge();
    check("midrst_done_next", 32'(fd_cnt - fd0), 1);
    check("midrst_relock", 32'(locked), 1);
    check("midrst_sum_0001", 32'(frame_sum), CSUM ? 32'h20 : 32'h0);

    // Checksum wrap and mixed-byte data.
    body(4, 8, 16'h1000);
    frame_edge();
    check("sum_1000_wraps", 32'(frame_sum), 32'h0);
    body(4, 8, 16'h0101);
    frame_edge();
    check("sum_0101", 32'(frame_sum), CSUM ? 32'h2020 : 32'h0);
    check("end_locked", 32'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
